// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - RV32M multiply/divide sequencer with pipeline stall.
// Optional MDU_FAST_MUL_EN: single-cycle 33x33 signed multiply for MUL/MULH/MULHSU/MULHU.
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNC3,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  input  logic            FLUSH,
  output logic            STALL,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [2:0]      op;
  logic [4:0]      cnt;
  logic            neg_res;
  logic [XLEN-1:0] opnd;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic            done_r;
  logic [XLEN-1:0] result_r;

  logic            accept;
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            sign_a;
  logic            sign_b;
  logic            neg_start;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;
  logic            fast_op;
  logic [XLEN-1:0] fast_res;

  assign accept   = (state == S_IDLE) && START && !FLUSH;
  assign is_div   = FUNC3[2];
  assign a_signed = (FUNC3 == 3'b001) || (FUNC3 == 3'b010) ||
                    (FUNC3 == 3'b100) || (FUNC3 == 3'b110);
  assign b_signed = (FUNC3 == 3'b001) || (FUNC3 == 3'b100) || (FUNC3 == 3'b110);
  assign sign_a   = a_signed & OPERAND_A[XLEN-1];
  assign sign_b   = b_signed & OPERAND_B[XLEN-1];
  assign mag_a    = sign_a ? -OPERAND_A : OPERAND_A;
  assign mag_b    = sign_b ? -OPERAND_B : OPERAND_B;

  // Remainders follow the dividend sign; products and quotients the xor of both.
  assign neg_start = (FUNC3[2] && FUNC3[1]) ? sign_a : (sign_a ^ sign_b);

  assign div_zero = is_div && (OPERAND_B == '0);
  assign div_ovf  = ((FUNC3 == 3'b100) || (FUNC3 == 3'b110)) &&
                    (OPERAND_A == MIN_NEG) && (OPERAND_B == '1);

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = FUNC3[1] ? OPERAND_A : '1;
    else
      special_res = FUNC3[1] ? '0 : MIN_NEG;
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a;
  logic signed [2*XLEN-1:0] fast_b;
  logic signed [2*XLEN-1:0] fast_prod;

  // 33-bit signed operands (sign bit or zero on top), extended so the product is exact.
  assign fast_a    = {{(XLEN){a_signed & OPERAND_A[XLEN-1]}}, OPERAND_A};
  assign fast_b    = {{(XLEN){b_signed & OPERAND_B[XLEN-1]}}, OPERAND_B};
  assign fast_prod = fast_a * fast_b;
  assign fast_op   = !is_div;
  assign fast_res  = (FUNC3 == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_op  = 1'b0;
  assign fast_res = '0;
`endif

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_trial;
  logic [XLEN-1:0] div_shift;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
  assign div_trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opnd};
  assign div_shift = {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = neg_res ? -acc_lo : acc_lo;
  assign rem_fix  = neg_res ? -acc_hi : acc_hi;

  always_comb begin
    fix_res = '0;
    case (op)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      op       <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (FLUSH) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (START) begin
              op      <= FUNC3;
              neg_res <= neg_start;
              cnt     <= 5'd31;
              if (div_zero || div_ovf) begin
                result_r <= special_res;
                done_r   <= 1'b1;
                state    <= S_DONE;
              end else if (fast_op) begin
                result_r <= fast_res;
                done_r   <= 1'b1;
                state    <= S_DONE;
              end else begin
                // Multiply: multiplier shifts out of acc_lo. Divide: dividend shifts out of acc_lo.
                acc_hi <= '0;
                acc_lo <= is_div ? mag_a : mag_b;
                opnd   <= is_div ? mag_b : mag_a;
                state  <= S_CALC;
              end
            end
          end
          S_CALC: begin
            if (op[2]) begin
              acc_hi <= div_trial[XLEN] ? div_shift : div_trial[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], ~div_trial[XLEN]};
            end else begin
              acc_hi <= mul_sum[XLEN:1];
              acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
            if (cnt == 5'd0) begin
              state <= S_FIXUP;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end
          S_FIXUP: begin
            result_r <= fix_res;
            done_r   <= 1'b1;
            state    <= S_DONE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign BUSY   = (state == S_CALC) || (state == S_FIXUP);
  assign STALL  = accept || BUSY;
  assign DONE   = done_r;
  assign RESULT = result_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - scoreboard bench for mdu_sequencer with a 64-bit arithmetic reference model.
`timescale 1ns/1ps
module tb_mdu_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic        FLUSH;
  logic [2:0]  FUNC3;
  logic [31:0] OPERAND_A;
  logic [31:0] OPERAND_B;
  logic        STALL;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int checks    = 0;
  int failures  = 0;
  int cycle     = 0;
  int stall_cnt = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_res = 32'h0;

  mdu_sequencer #(.XLEN(32)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .FUNC3     (FUNC3),
    .OPERAND_A (OPERAND_A),
    .OPERAND_B (OPERAND_B),
    .FLUSH     (FLUSH),
    .STALL     (STALL),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    int              sa;
    int              sbv;
    sa  = a;
    sbv = b;
    case (f)
      3'd0: begin p = longint'(sa) * longint'(sbv); return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sbv); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'h0, b}); return p[63:32]; end
      3'd3: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sbv;
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sbv;
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'h0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 34;
  endfunction

  task automatic wait_idle();
    int waited = 0;
    @(posedge CLK); #2;
    while ((BUSY || DONE) && waited < 100) begin
      @(posedge CLK); #2;
      waited++;
    end
    if (waited >= 100) check("idle_wait", {31'b0, BUSY | DONE}, 32'h0);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    START     = 1'b1;
    FUNC3     = f;
    OPERAND_A = a;
    OPERAND_B = b;
    e.res     = model(f, a, b);
    e.lat     = latency(f, a, b);
    e.issue   = cycle;
    sb.push_back(e);
    last_res  = e.res;
    @(posedge CLK); #2;
    START     = 1'b0;
    FUNC3     = 3'($urandom_range(0, 7));
    OPERAND_A = $urandom;
    OPERAND_B = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: counts stall cycles per accepted request and scores every DONE pulse.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (START && !BUSY && !DONE && !FLUSH) stall_cnt = 0;
        if (STALL) stall_cnt++;
        if (DONE) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual_result=0x%08h expected no DONE pulse", RESULT);
          end else begin
            mon_e = sb.pop_front();
            check("result", RESULT, mon_e.res);
            check("latency", 32'(cycle - mon_e.issue), 32'(mon_e.lat));
            check("stall_cycles", 32'(stall_cnt), 32'(mon_e.lat));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    RESET     = 1'b1;
    START     = 1'b0;
    FLUSH     = 1'b0;
    FUNC3     = 3'd0;
    OPERAND_A = 32'h0;
    OPERAND_B = 32'h0;
    repeat (3) @(posedge CLK);
    #2;
    check("reset_busy",   {31'b0, BUSY},  32'h0);
    check("reset_done",   {31'b0, DONE},  32'h0);
    check("reset_stall",  {31'b0, STALL}, 32'h0);
    check("reset_result", RESULT,         32'h0);
    RESET = 1'b0;

    issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    issue(3'd4, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(3'd6, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(3'd7, 32'd100, 32'd7);
    issue(3'd5, 32'hDEAD_BEEF, 32'h0);
    issue(3'd6, 32'h1234_5678, 32'h0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush at CALC cycle 10: no DONE, RESULT keeps the previous value.
    wait_idle();
    START = 1'b1; FUNC3 = 3'd4; OPERAND_A = 32'h0001_0000; OPERAND_B = 32'd3;
    @(posedge CLK); #2;
    START = 1'b0;
    repeat (9) begin @(posedge CLK); #2; end
    FLUSH = 1'b1;
    @(posedge CLK); #2;
    FLUSH = 1'b0;
    check("flush_busy",   {31'b0, BUSY}, 32'h0);
    check("flush_result", RESULT,        last_res);
    @(posedge CLK); #2;
    check("flush_no_done", {31'b0, DONE}, 32'h0);
    issue(3'd5, 32'd1000, 32'd9);

    // FLUSH together with START: nothing latched, no stall.
    wait_idle();
    START = 1'b1; FLUSH = 1'b1; FUNC3 = 3'd4; OPERAND_A = 32'd50; OPERAND_B = 32'd0;
    #1;
    check("flush_start_stall", {31'b0, STALL}, 32'h0);
    @(posedge CLK); #2;
    START = 1'b0; FLUSH = 1'b0;
    check("flush_start_busy", {31'b0, BUSY | DONE}, 32'h0);
    check("flush_start_result", RESULT, last_res);

    // Asynchronous reset mid-CALC.
    wait_idle();
    START = 1'b1; FUNC3 = 3'd1; OPERAND_A = 32'h1234_5678; OPERAND_B = 32'h9ABC_DEF0;
    @(posedge CLK); #2;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    check("rst_mid_busy",   {31'b0, BUSY},  32'h0);
    check("rst_mid_stall",  {31'b0, STALL}, 32'h0);
    check("rst_mid_done",   {31'b0, DONE},  32'h0);
    check("rst_mid_result", RESULT,         32'h0);
    last_res = 32'h0;
    @(posedge CLK); #2;
    RESET = 1'b0;

    // START while busy must be ignored; the scoreboard holds only the first op.
    issue(3'd5, 32'hFFFF_0000, 32'd17);
    repeat (3) begin @(posedge CLK); #2; end
    START = 1'b1; FUNC3 = 3'd0; OPERAND_A = 32'd5; OPERAND_B = 32'd6;
    @(posedge CLK); #2;
    START = 1'b0;

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end

    begin
      int drain = 0;
      while (sb.size() != 0 && drain < 200) begin
        @(posedge CLK);
        drain++;
      end
      check("scoreboard_drain", 32'(sb.size()), 32'h0);
    end
    repeat (4) @(posedge CLK);
    #2;
    check("final_idle", {31'b0, BUSY | DONE | STALL}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
